// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, variable-latency memory between the instruction
// fetch port (i_*) and the data port (d_*). Requests are serialised onto the
// registered memory port (m_*). Ties in IDLE alternate with the last grant,
// and a watchdog aborts any access the memory fails to complete within
// TimeoutCycles cycles, signalling it through the port's err flag.
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   i_req, i_addr     fetch request and address (held until i_ack)
//   i_rdata, i_ack,   fetch completion, read data and timeout flag
//   i_err
//   d_req, d_we,      data request, write enable, address, write data
//   d_addr, d_wdata   (held until d_ack)
//   d_rdata, d_ack,   data completion, read data (0 on writes) and
//   d_err             timeout flag
//   m_req, m_we,      registered memory request, write enable, address
//   m_addr, m_wdata   and write data; stable for the whole access
//   m_rdata, m_ready  memory read data and completion strobe
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int Width         = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic [Width-1:0] i_addr,
    output logic [Width-1:0] i_rdata,
    output logic             i_ack,
    output logic             i_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [Width-1:0] d_addr,
    input  logic [Width-1:0] d_wdata,
    output logic [Width-1:0] d_rdata,
    output logic             d_ack,
    output logic             d_err,
    output logic             m_req,
    output logic             m_we,
    output logic [Width-1:0] m_addr,
    output logic [Width-1:0] m_wdata,
    input  logic [Width-1:0] m_rdata,
    input  logic             m_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    // Counter value seen in the last allowed waiting cycle.
    localparam logic [7:0] CntLast = 8'(TimeoutCycles - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_d;      // 1: data port was granted last
    logic [7:0]       r_cnt;
    logic             r_m_req;
    logic             r_m_we;
    logic [Width-1:0] r_m_addr;
    logic [Width-1:0] r_m_wdata;

    logic             w_grant_i;
    logic             w_grant_d;
    logic             w_done;
    logic             w_timeout;

    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        i_ack       = 1'b0;
        i_err       = 1'b0;
        i_rdata     = '0;
        d_ack       = 1'b0;
        d_err       = 1'b0;
        d_rdata     = '0;

        case (r_state)
            S_IDLE: begin
                // Data wins when alone, or on a tie when fetch was granted last.
                if (d_req && (!i_req || !r_last_d)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_DATA;
                end else if (i_req) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH, S_DATA: begin
                // m_ready takes precedence over a timeout in the same cycle.
                w_timeout = !m_ready && (r_cnt == CntLast);
                w_done    = m_ready || w_timeout;
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
                if (r_state == S_FETCH) begin
                    i_ack   = w_done;
                    i_err   = w_timeout;
                    i_rdata = m_ready ? m_rdata : '0;
                end else begin
                    d_ack   = w_done;
                    d_err   = w_timeout;
                    d_rdata = (m_ready && !r_m_we) ? m_rdata : '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last_d  <= 1'b0;
            r_cnt     <= '0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else if (w_grant_d) begin
            r_last_d  <= 1'b1;
            r_cnt     <= '0;
            r_m_req   <= 1'b1;
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
        end else if (w_grant_i) begin
            r_last_d  <= 1'b0;
            r_cnt     <= '0;
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= i_addr;
            r_m_wdata <= '0;
        end else if (w_done) begin
            r_m_req   <= 1'b0;
        end else if (r_state != S_IDLE) begin
            r_cnt     <= r_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int W   = 32;
    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_req;
    logic [W-1:0] i_addr;
    logic [W-1:0] i_rdata;
    logic         i_ack;
    logic         i_err;
    logic         d_req;
    logic         d_we;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic [W-1:0] d_rdata;
    logic         d_ack;
    logic         d_err;
    logic         m_req;
    logic         m_we;
    logic [W-1:0] m_addr;
    logic [W-1:0] m_wdata;
    logic [W-1:0] m_rdata;
    logic         m_ready;

    always #5 clk = ~clk;

    mem_arbiter #(.Width(W), .TimeoutCycles(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ack   (i_ack),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_ack   (d_ack),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          ack_count = 0;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int          wait_cycles = 0;
    int          mcnt = 0;

    // Memory model: completes after wait_cycles wait states.
    assign m_ready = m_req && (mcnt == wait_cycles);
    assign m_rdata = m_req ? mem[m_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (!m_req || m_ready) mcnt <= 0;
        else                   mcnt <= mcnt + 1;
        if (m_req && m_ready && m_we) mem[m_addr[9:2]] = m_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit is_d, input logic [31:0] rd, input bit err);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rd;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every ack pops the next expected completion.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (i_ack || d_ack) begin
            ack_count++;
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check("ack_port", 32'(d_ack), 32'(e.is_d));
                check("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
                check("ack_err", 32'(d_ack ? d_err : i_err), 32'(e.err));
                check("other_port_zero",
                      d_ack ? (i_rdata | 32'(i_ack | i_err)) : (d_rdata | 32'(d_ack | d_err)),
                      32'(0));
            end
        end
    end

    task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int waits, input bit mutate);
        int lat;
        bit tmo;
        bit ack;
        tmo = (waits >= TMO);
        wait_cycles = waits;
        if (is_d && we) push_exp(1'b1, 32'h0, tmo);
        else            push_exp(is_d, tmo ? 32'h0 : ref_mem[addr[9:2]], tmo);
        if (is_d && we && !tmo) ref_mem[addr[9:2]] = wdata;
        @(posedge clk); #1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        lat = 0;
        ack = 1'b0;
        while (!ack && lat <= 40) begin
            @(negedge clk);
            ack = is_d ? d_ack : i_ack;
            if (m_req) begin
                check("m_we", 32'(m_we), 32'(is_d && we));
                check("m_addr", m_addr, addr);
                if (is_d && we) check("m_wdata", m_wdata, wdata);
                if (mutate) begin
                    d_wdata = ~wdata;
                    d_addr  = addr + 32'd4;
                end
            end
            if (!ack) lat++;
        end
        check("latency", 32'(lat), 32'(tmo ? TMO : waits + 1));
        @(posedge clk); #1;
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check("m_req_drop", 32'(m_req), 32'(0));
    endtask

    task automatic wait_acks(input int target, input string tag);
        int base;
        base = ack_count;
        for (int k = 0; k < 80 && (ack_count - base) < target; k++) begin
            @(negedge clk); #1;
        end
        check(tag, 32'(ack_count - base), 32'(target));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        mem[4]     = 32'h0050_0113;
        ref_mem[4] = 32'h0050_0113;

        // Reset with a fetch request already pending.
        reset = 1'b0; i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        wait_cycles = 0;
        push_exp(1'b0, 32'h0050_0113, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_req", 32'(m_req), 32'(0));
        check("rst_i_ack", 32'(i_ack), 32'(0));
        check("rst_d_ack", 32'(d_ack), 32'(0));
        check("rst_errs", 32'({i_err, d_err}), 32'(0));
        check("rst_rdata", i_rdata | d_rdata, 32'(0));
        check("rst_m_bus", m_addr | m_wdata | 32'(m_we), 32'(0));
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("grant_cycle_m_req", 32'(m_req), 32'(0));
        check("grant_cycle_i_ack", 32'(i_ack), 32'(0));
        @(negedge clk);
        check("fetch_m_req", 32'(m_req), 32'(1));
        check("fetch_ack", 32'(i_ack), 32'(1));
        check("fetch_rdata", i_rdata, 32'h0050_0113);
        check("fetch_err", 32'(i_err), 32'(0));
        @(posedge clk); #1 i_req = 1'b0;
        @(negedge clk);
        check("fetch_m_req_drop", 32'(m_req), 32'(0));

        // Both requesters held from reset: D, F, D, F, D, F.
        reset = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h20; d_addr = 32'h40; d_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("tie_rst_m_req", 32'(m_req), 32'(0));
        check("tie_rst_acks", 32'({i_ack, d_ack}), 32'(0));
        for (int k = 0; k < 3; k++) begin
            push_exp(1'b1, ref_mem[32'h40 >> 2], 1'b0);
            push_exp(1'b0, ref_mem[32'h20 >> 2], 1'b0);
        end
        @(posedge clk); #1 reset = 1'b1;
        wait_acks(6, "tie_acks");
        @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;

        // Directed accesses.
        do_access(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3, 1'b1);
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 1'b0);
        do_access(1'b0, 1'b0, 32'h30, 32'h0, 2, 1'b0);
        do_access(1'b1, 1'b0, 32'h80, 32'h0, 255, 1'b0);
        do_access(1'b0, 1'b0, 32'h84, 32'h0, 255, 1'b0);
        do_access(1'b1, 1'b0, 32'h88, 32'h0, TMO - 1, 1'b0);
        do_access(1'b1, 1'b1, 32'h8C, 32'h1234_5678, 255, 1'b0);

        // Reset in the middle of a stalled data access.
        @(posedge clk); #1;
        wait_cycles = 255; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_data", 32'(m_req), 32'(1));
        reset = 1'b0; i_req = 1'b1; i_addr = 32'h94;
        @(posedge clk); #1 wait_cycles = 0;
        @(negedge clk);
        check("abort_m_req", 32'(m_req), 32'(0));
        check("abort_d_ack", 32'(d_ack), 32'(0));
        push_exp(1'b1, ref_mem[32'h90 >> 2], 1'b0);
        push_exp(1'b0, ref_mem[32'h94 >> 2], 1'b0);
        reset = 1'b1;
        wait_acks(2, "post_reset_tie_acks");
        @(posedge clk); #1 i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-port, variable-latency memory between the pipeline's instruction-fetch port and its data port. It sits between the core and a unified instruction/data memory. Each requester issues a request, and the arbiter serialises the requests onto the memory port. An access completes only when the arbiter returns an acknowledge. The core's hazard logic treats the absence of that acknowledge as a stall: fetch waits on `i_ack`, and memory-stage data access waits on `d_ack`. A watchdog counter terminates any access the memory never completes, and flags it as an error.

## Interface
- `Width`, 32, address and data width
- `TimeoutCycles`, 255, maximum cycles an access waits for `m_ready` before it is aborted (1..255)
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`
- `i_req`  in  1  fetch request; held high with `i_addr` stable until `i_ack`
- `i_addr`  in  Width  fetch address
- `i_rdata`  out  Width  fetch read data; valid only while `i_ack`=1
- `i_ack`  out  1  fetch completion, one cycle per access
- `i_err`  out  1  fetch access timed out; valid only while `i_ack`=1
- `d_req`  in  1  data request; held with `d_we`, `d_addr`, `d_wdata` stable until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  Width  data address
- `d_wdata`  in  Width  write data
- `d_rdata`  out  Width  data read value; valid only while `d_ack`=1
- `d_ack`  out  1  data completion, one cycle per access
- `d_err`  out  1  data access timed out; valid only while `d_ack`=1
- `m_req`  out  1  memory request (registered)
- `m_we`  out  1  memory write enable (registered)
- `m_addr`  out  Width  memory address (registered)
- `m_wdata`  out  Width  memory write data (registered)
- `m_rdata`  in  Width  memory read data; valid in the cycle `m_ready`=1
- `m_ready`  in  1  memory completes the current access in this cycle

## Operation
- The FSM has three states: IDLE, FETCH and DATA.
- IDLE, arbitration:
  - Only `d_req` high: go to DATA.
  - Only `i_req` high: go to FETCH.
  - Both high: grant the port not granted last. `last_grant` resets to FETCH, so data wins the first tie.
  - On a grant, latch the address, write enable and write data into the `m_*` registers, set `m_req`=1, clear the timeout counter and update `last_grant`.
  - No request: stay in IDLE with `m_req`=0.
- FETCH/DATA, waiting for memory:
  - `m_ready`=1: drive the granted port's ack high combinationally in this cycle, with rdata = `m_rdata` and err=0. Return to IDLE at the next edge and clear `m_req`.
  - `m_ready`=0 and the counter equals `TimeoutCycles`-1: drive the ack high with err=1 and rdata=0, then return to IDLE and clear `m_req`. Otherwise increment the counter.
- Write accesses drive rdata=0 on ack.
- `m_we` is 0 during FETCH.
- The non-granted port's ack, err and rdata are 0.
- `i_ack` and `d_ack` are never high in the same cycle.
- `m_*` hold their values for the whole access; they do not follow changes on the requester inputs after the grant.
- A request that drops before its ack is a protocol violation; the arbiter still completes the latched access.
- Reset (`reset`=0 at an edge) takes effect whatever the current state:
  - state goes to IDLE, `last_grant` to FETCH, counter to 0
  - `m_req`, `m_we`, `m_addr` and `m_wdata` go to 0
  - any in-flight access is abandoned and no ack is issued for it
- Reset values of the combinational outputs (while in IDLE): `i_ack`, `d_ack`, `i_err`, `d_err`, `i_rdata` and `d_rdata` are all 0.

## Timing
- Grant occurs at the first edge on which IDLE sees a request. `m_req` is high from the next cycle.
- Minimum latency, with `m_ready` high in the first cycle of `m_req`: request in cycle 0, ack in cycle 1.
- Ack occurs in the same cycle as `m_ready`. Latency is 1 + (memory wait cycles).
- Each access spends one cycle in IDLE after completion. Maximum throughput is one access per 2 cycles.
- A requester holding req across its ack edge is seen as a new request in IDLE. Requesters must drop or re-present req the cycle after ack.
- A timed-out access acks in the `TimeoutCycles`-th cycle after `m_req` rises.
- Memory contract: `m_ready` is ignored in IDLE, and data is valid only when `m_ready`=1.

## Test plan
- Reset with `reset`=0, holding `i_req`=1 -> `m_req`=0, both acks 0. Release reset -> FETCH grant, `m_req`=1 the next cycle.
- Fetch at 0x0000_0010, memory returns 0x0050_0113 with 0 wait states -> `i_ack`=1 and `i_rdata`=0x0050_0113 exactly 1 cycle after `i_req`, `i_err`=0.
- `i_req` and `d_req` both high from reset -> data granted first, then fetch. Keep both asserted -> grants alternate D, F, D, F and neither starves.
- Data write of 0xDEAD_BEEF to 0x0000_0100, `m_ready` delayed 3 cycles, requester changes `d_wdata` mid-access -> `m_we`=1 with `m_addr`/`m_wdata` stable at the latched values, `d_ack` on the 4th `m_req` cycle, `d_rdata`=0.
- `TimeoutCycles`=8, `m_ready` held 0 -> `d_ack`=1, `d_err`=1, `d_rdata`=0 in the 8th `m_req` cycle, then `m_req`=0.
- Pull `reset` low while in DATA with `m_ready` low -> next cycle state IDLE and `m_req`=0, no `d_ack`. The first tie after reset is won by data.
